subleq_core: RTL
================

# subleq_core

Execution unit of the SUBLEQ machine and the initiator on the single-port word memory bus. Each instruction is three words A, B, C at pc, pc+1, pc+2. The core computes mem[B] := mem[B] − mem[A], then jumps to C if the result is ≤ 0 (signed), else to pc+3. Every access is one bus cycle: the memory returns read data combinationally in the same cycle and commits writes on the rising clock edge when store is high.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE `` (defines.vh): data/address width W; memory depth 2^W.
- `clk`  in  1  system clock, rising edge.
- `areset`  in  1  reset, asynchronous, active-low.
- `run`  in  1  permit starting a new instruction.
- `load`  out  1  read strobe to memory.
- `store`  out  1  write strobe; memory writes mem_in to addr at the next rising clk.
- `addr`  out  W  bus address.
- `mem_in`  out  W  write data to memory.
- `mem_out`  in  W  read data from memory, valid in the same cycle as load/addr.
- `pc`  out  W  current instruction address (debug).
- `halted`  out  1  core stopped on a halt jump.

## Operation
- Registers: pc, a, b, c, va, vb (W bits each), state, halted.
- FSM states and per-state bus drive:
  - FETCH_A: if run, load=1, addr=pc; a<=mem_out → FETCH_B. If !run, all strobes 0; stay in FETCH_A.
  - FETCH_B: load=1, addr=pc+1; b<=mem_out → FETCH_C.
  - FETCH_C: load=1, addr=pc+2; c<=mem_out → READ_A.
  - READ_A: load=1, addr=a; va<=mem_out → READ_B.
  - READ_B: load=1, addr=b; vb<=mem_out → WRITE.
  - WRITE: store=1, addr=b, mem_in=r where r=vb−va mod 2^W.
    - If r[W−1]=1 or r=0, the jump is taken: pc<=c. If c is all-ones, set halted<=1 → HALT; otherwise → FETCH_A.
    - Else pc<=pc+3 mod 2^W → FETCH_A.
  - HALT: load=0, store=0; stays in HALT until reset.
- load and store are never both 1.
- In any state with no strobe, addr=0 and mem_in=0.
- Addresses pc+1, pc+2 and pc+3 wrap modulo 2^W.
- run is sampled only in FETCH_A. Deasserting run mid-instruction does not stop the instruction in progress.
- Aliasing is handled naturally by the fixed order:
  - A=B gives r=0, so the jump is taken.
  - Writing into the current instruction's own words takes effect from the next fetch.

## Timing
- Outputs are Moore-style, combinational from state and registers only. No combinational path exists from mem_out to any output.
- Instruction latency is 6 cycles: FETCH_A through WRITE.
- Stalled cycles in FETCH_A add to the latency.
- On areset low, asynchronously: state=FETCH_A, pc=0, halted=0, all data registers 0. Outputs are then load=0 (run ignored while in reset), store=0, addr=0, mem_in=0.
- A reset arriving mid-instruction aborts it. If reset lands in WRITE before the clock edge, no write occurs.
- The first load appears in the first cycle after areset goes high with run=1, with addr=0.

## Test plan
- **Reset:** hold areset=0 with run=1 → load=0, store=0, addr=0, pc=0, halted=0. Release areset → next cycle load=1, addr=0.
- **Jump not taken** (W=8): mem[0..2]=3,4,9, mem[3]=5, mem[4]=7.
  - 6th cycle: store=1, addr=4, mem_in=2.
  - Then pc=3 and mem[4]=2.
- **Jump taken:** same program with mem[3]=7, mem[4]=7.
  - mem_in=0 and pc becomes 9.
  - Repeat with mem[4]=6: r=0xFF, pc=9.
- **Halt:** instruction with C=0xFF and a taken jump.
  - halted=1 after the WRITE cycle.
  - load and store stay 0 for 20 subsequent cycles.
  - pc=0xFF.
- **Wrap and stall:**
  - Instruction at pc=0xFD not taken → fetch addresses FD, FE, FF, then pc=0x00.
  - run=0 at FETCH_A → no strobes until run=1.
  - Lowering run during READ_A still completes the write.
- **Reset mid-op:** pull areset low during WRITE, before the edge → store drops immediately and the memory word is unchanged.

Source files
------------

// File: rtl/subleq_core.sv
// subleq_core: SUBLEQ execution unit driving a single-port word memory bus,
// one bus access per cycle, six cycles per instruction.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
module subleq_core #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  output logic                 load,
  output logic                 store,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] mem_in,
  input  logic [WORD_SIZE-1:0] mem_out,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 halted
);
  localparam int W = WORD_SIZE;
  localparam logic [2:0] FETCH_A = 3'd0;
  localparam logic [2:0] FETCH_B = 3'd1;
  localparam logic [2:0] FETCH_C = 3'd2;
  localparam logic [2:0] READ_A  = 3'd3;
  localparam logic [2:0] READ_B  = 3'd4;
  localparam logic [2:0] WRITE   = 3'd5;
  localparam logic [2:0] HALT    = 3'd6;
  logic [2:0]   state_q, state_d;
  logic [W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, c_q, c_d, va_q, va_d, vb_q, vb_d;
  logic         halted_q, halted_d;
  logic [W-1:0] r, addr_raw;
  logic         taken, stop, fa_go;
  always_comb begin
    r        = vb_q - va_q;
    taken    = r[W-1] | (r == '0);
    stop     = taken & (&c_q);
    fa_go    = (state_q == FETCH_A) & run;
    // areset gate keeps load low while held in reset despite run
    load     = areset & (fa_go | (state_q inside {FETCH_B, FETCH_C, READ_A, READ_B}));
    store    = areset & (state_q == WRITE);
    addr_raw = (state_q == FETCH_A) ? pc_q :
               (state_q == FETCH_B) ? pc_q + W'(1) :
               (state_q == FETCH_C) ? pc_q + W'(2) :
               (state_q == READ_A)  ? a_q : b_q;
    addr     = (load | store) ? addr_raw : '0;
    mem_in   = store ? r : '0;
    pc       = pc_q;
    halted   = halted_q;
    a_d      = fa_go ? mem_out : a_q;
    b_d      = (state_q == FETCH_B) ? mem_out : b_q;
    c_d      = (state_q == FETCH_C) ? mem_out : c_q;
    va_d     = (state_q == READ_A) ? mem_out : va_q;
    vb_d     = (state_q == READ_B) ? mem_out : vb_q;
    pc_d     = (state_q == WRITE) ? (taken ? c_q : pc_q + W'(3)) : pc_q;
    halted_d = halted_q | ((state_q == WRITE) & stop);
    state_d  = (state_q == FETCH_A) ? (run ? FETCH_B : FETCH_A) :
               (state_q == WRITE)   ? (stop ? HALT : FETCH_A) :
               (state_q == HALT)    ? HALT : state_q + 3'd1;
  end
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q  <= FETCH_A;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      halted_q <= halted_d;
    end
  end
endmodule
